if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 89 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect select and IF/ID pipeline register.
// Optional MIPS delay slot behaviour via `IF_BRANCH_DELAY_SLOT_EN.
module if_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  PCSrc,
   input  logic        Branch,
   input  logic        Zero,
   input  logic [31:0] jr_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid,
   output logic [5:0]  OpCode,
   output logic [5:0]  Funct
);

   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic [31:0] brOffset;
   logic [31:0] target;
   logic        isJr;
   logic        isJ;
   logic        isBr;
   logic        redirect;
   logic        flushSlot;
   logic        unusedJrLow;

   assign pcPlus4   = pc + 32'd4;
   assign imem_addr = pc;
   assign OpCode    = id_instr[31:26];
   assign Funct     = id_instr[5:0];

   assign isJr     = (PCSrc == 2'b10);
   assign isJ      = (PCSrc == 2'b01);
   assign isBr     = Branch & Zero;
   assign redirect = id_valid & ~stall & (isJr | isJ | isBr);
   assign brOffset = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

   assign unusedJrLow = ^jr_target[1:0];

   // jr beats j beats beq when several are asserted together
   always_comb begin
      target = id_pc_plus4 + brOffset;
      if (isJr)
         target = {jr_target[31:2], 2'b00};
      else if (isJ)
         target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
   end

`ifdef IF_BRANCH_DELAY_SLOT_EN
   assign flushSlot = 1'b0;
`else
   assign flushSlot = redirect;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= 32'd0;
      end else if (!stall) begin
         if (redirect)
            pc <= target;
         else if (imem_ready)
            pc <= pcPlus4;
      end
   end

   // bubbles keep id_pc_plus4 so the last real PC+4 stays visible
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_instr    <= 32'd0;
         id_pc_plus4 <= 32'd0;
         id_valid    <= 1'b0;
      end else if (!stall) begin
         if (flushSlot || !imem_ready) begin
            id_instr <= 32'd0;
            id_valid <= 1'b0;
         end else begin
            id_instr    <= imem_rdata;
            id_pc_plus4 <= pcPlus4;
            id_valid    <= 1'b1;
         end
      end
   end

endmodule
